// File: rtl/snake_move_scheduler.sv
// ============================================================================
// Module   : snake_move_scheduler
// Brief    : Snake game sequencer: button decode, frame-paced step pulses,
//            collision/food handling, growth, score and game-over.
//            Optional speed-up per food when SNAKE_SPEEDUP_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module snake_move_scheduler #(
  parameter int FRAMES_PER_STEP = 8,
  parameter int MIN_FRAMES      = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] btn_n,
  input  logic       restart,
  input  logic       frame_tick,
  input  logic       collide,
  input  logic       food_hit,
  output logic [2:0] direction,
  output logic       step,
  output logic       grow,
  output logic       game_over,
  output logic [7:0] score
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b010;
  localparam logic [2:0] DIR_LEFT  = 3'b011;
  localparam logic [2:0] DIR_RIGHT = 3'b100;
  localparam logic [2:0] DIR_NONE  = 3'b111;

  // Start period never sits below the speed-up floor, even if misconfigured.
  localparam int         START_FRAMES = (FRAMES_PER_STEP < MIN_FRAMES) ? MIN_FRAMES : FRAMES_PER_STEP;
  localparam logic [7:0] PERIOD_INIT  = 8'(START_FRAMES);
  localparam logic [7:0] PERIOD_MIN   = 8'(MIN_FRAMES);

  logic [2:0] state;
  logic [2:0] pending;
  logic [7:0] frame_cnt;
  logic [7:0] period;
  logic [2:0] cand;
  logic       cand_valid;
  logic       reverse;
  logic       accept;

  always_comb begin
    cand       = DIR_NONE;
    cand_valid = 1'b1;
    if (!btn_n[3])      cand = DIR_UP;
    else if (!btn_n[2]) cand = DIR_DOWN;
    else if (!btn_n[1]) cand = DIR_LEFT;
    else if (!btn_n[0]) cand = DIR_RIGHT;
    else                cand_valid = 1'b0;
  end

  always_comb begin
    reverse = 1'b0;
    case (direction)
      DIR_UP:    reverse = (cand == DIR_DOWN);
      DIR_DOWN:  reverse = (cand == DIR_UP);
      DIR_LEFT:  reverse = (cand == DIR_RIGHT);
      DIR_RIGHT: reverse = (cand == DIR_LEFT);
      default:   reverse = 1'b0;
    endcase
  end

  assign accept    = cand_valid && !reverse && (state != S_OVER);
  assign step      = (state == S_STEP);
  assign game_over = (state == S_OVER);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      direction <= DIR_NONE;
      pending   <= DIR_NONE;
      frame_cnt <= 8'd0;
      period    <= PERIOD_INIT;
      score     <= 8'd0;
      grow      <= 1'b0;
    end else if (restart) begin
      state     <= S_IDLE;
      direction <= DIR_NONE;
      pending   <= DIR_NONE;
      frame_cnt <= 8'd0;
      period    <= PERIOD_INIT;
      score     <= 8'd0;
      grow      <= 1'b0;
    end else begin
      grow <= 1'b0;
      if (accept) pending <= cand;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_RUN;
            frame_cnt <= 8'd0;
          end
        end
        S_RUN: begin
          if (frame_tick) begin
            if (frame_cnt == period - 8'd1) begin
              frame_cnt <= 8'd0;
              direction <= pending;
              state     <= S_STEP;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        S_STEP: state <= S_CHECK;
        S_CHECK: begin
          if (collide) begin
            state <= S_OVER;
          end else begin
            if (food_hit) begin
              grow <= 1'b1;
              if (score != 8'hFF) score <= score + 8'd1;
`ifdef SNAKE_SPEEDUP_EN
              if (period > PERIOD_MIN) period <= period - 8'd1;
`else
              period <= period;
`endif
            end
            state <= S_RUN;
          end
        end
        S_OVER:  state <= S_OVER;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_snake_move_scheduler.sv
// ============================================================================
// Module   : tb_snake_move_scheduler
// Brief    : Directed vector bench for snake_move_scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_snake_move_scheduler;

  localparam int FPS  = 8;
  localparam int MINF = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] btn_n = 4'hF;
  logic       restart = 1'b0;
  logic       frame_tick = 1'b0;
  logic       collide = 1'b0;
  logic       food_hit = 1'b0;
  logic [2:0] direction;
  logic       step;
  logic       grow;
  logic       game_over;
  logic [7:0] score;

  snake_move_scheduler #(.FRAMES_PER_STEP(FPS), .MIN_FRAMES(MINF)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_n      (btn_n),
    .restart    (restart),
    .frame_tick (frame_tick),
    .collide    (collide),
    .food_hit   (food_hit),
    .direction  (direction),
    .step       (step),
    .grow       (grow),
    .game_over  (game_over),
    .score      (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] b1;
    logic [3:0] b2;
    logic       food;
    logic       coll;
    logic [2:0] dir;
    logic       grow_e;
    logic       over;
    int         score_e;
  } vec_t;

  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_period;
  int   exp_score;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] b);
    if (b != 4'hF) begin
      btn_n = b;
      cyc();
      btn_n = 4'hF;
    end
  endtask

  // Returns the number of ticks issued until step is seen (0 if never).
  task automatic tick_until_step(output int cnt);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      if (step) begin
        cnt = i + 1;
        break;
      end
      cyc();
    end
  endtask

  task automatic step_period_check();
    int cnt;
    tick_until_step(cnt);
    chk("step_period", cnt, exp_period);
  endtask

  // From the STEP cycle: drive flags during CHECK, land in the following cycle.
  task automatic do_flags(input logic f, input logic c);
    cyc();
    food_hit = f;
    collide  = c;
    cyc();
    food_hit = 1'b0;
    collide  = 1'b0;
    if (f && !c) begin
      if (exp_score < 255) exp_score++;
`ifdef SNAKE_SPEEDUP_EN
      if (exp_period > MINF) exp_period--;
`endif
    end
  endtask

  initial begin
    int any_step;
    int grows;

    vecs[0] = '{4'hF, 4'hF, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 0};
    vecs[1] = '{4'b1011, 4'hF, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 0};
    vecs[2] = '{4'b1011, 4'b1101, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0, 1};
    vecs[3] = '{4'b0000, 4'hF, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 2};
    vecs[4] = '{4'b1110, 4'hF, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 2};
    vecs[5] = '{4'b1101, 4'hF, 1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 3};
    vecs[6] = '{4'b1011, 4'hF, 1'b1, 1'b1, 3'b010, 1'b0, 1'b1, 3};

    // Asynchronous reset with no clock edge involved
    #2 reset_n = 1'b0;
    #1;
    chk("reset_dir", direction, 7);
    chk("reset_score", score, 0);
    chk("reset_over", game_over, 0);
    chk("reset_step", step, 0);
    chk("reset_grow", grow, 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    exp_period = FPS;
    exp_score  = 0;

    press(4'b0111);
    chk("idle_dir_before_step", direction, 7);

    for (int v = 0; v < 7; v++) begin
      press(vecs[v].b1);
      press(vecs[v].b2);
      step_period_check();
      chk($sformatf("v%0d_dir", v), direction, vecs[v].dir);
      do_flags(vecs[v].food, vecs[v].coll);
      chk($sformatf("v%0d_grow", v), grow, vecs[v].grow_e);
      chk($sformatf("v%0d_score", v), score, vecs[v].score_e);
      chk($sformatf("v%0d_over", v), game_over, vecs[v].over);
      chk($sformatf("v%0d_score_model", v), score, exp_score);
      cyc();
      chk($sformatf("v%0d_grow_end", v), grow, 0);
    end

    // OVER holds: ticks and buttons are ignored
    any_step = 0;
    for (int i = 0; i < 20; i++) begin
      frame_tick = 1'b1;
      btn_n      = 4'b1101;
      cyc();
      frame_tick = 1'b0;
      btn_n      = 4'hF;
      if (step) any_step++;
      cyc();
    end
    chk("over_no_step", any_step, 0);
    chk("over_hold", game_over, 1);
    chk("over_dir_frozen", direction, 3'b010);
    chk("over_score_frozen", score, 3);

    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("restart_dir", direction, 7);
    chk("restart_over", game_over, 0);
    chk("restart_score", score, 0);
    exp_period = FPS;
    exp_score  = 0;

    // Restart asserted during CHECK with food present
    press(4'b1110);
    step_period_check();
    chk("rs_dir1", direction, 3'b100);
    do_flags(1'b1, 1'b0);
    chk("rs_score1", score, 1);
    step_period_check();
    cyc();
    food_hit = 1'b1;
    restart  = 1'b1;
    cyc();
    food_hit = 1'b0;
    restart  = 1'b0;
    chk("rs_no_grow", grow, 0);
    chk("rs_dir", direction, 7);
    chk("rs_score", score, 0);
    chk("rs_step", step, 0);
    cyc();
    chk("rs_no_grow_late", grow, 0);
    exp_period = FPS;
    exp_score  = 0;

    press(4'b0111);
    step_period_check();
    chk("rs_replay_dir", direction, 3'b001);

    // 256 foods: score saturates, every food grows
    grows = 0;
    do_flags(1'b1, 1'b0);
    if (grow) grows++;
    for (int k = 1; k < 256; k++) begin
      step_period_check();
      do_flags(1'b1, 1'b0);
      if (grow) grows++;
    end
    chk("sat_grows", grows, 256);
    chk("sat_score", score, 255);
    chk("sat_score_model", score, exp_score);
`ifdef SNAKE_SPEEDUP_EN
    chk("speed_floor", exp_period, MINF);
`endif
    step_period_check();

    // Async reset mid-game, between clock edges
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_dir", direction, 7);
    chk("async_score", score, 0);
    chk("async_step", step, 0);
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
